uart_rx_deframer: RTL and testbench

// - Receive end of the UART link: the counterpart to the TX path (serializer + parityCalc).
// - Oversamples serial RX_IN and detects the start bit; recovers 8 data bits LSB-first.
// - Checks optional parity (same PAR_TYP encoding as TX) and the stop bit.
// - Presents a parallel byte with a one-cycle Data_Valid strobe, or a one-cycle error flag.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sampler.sv | 56 +++++
 rtl/uart_rx_deframer.sv | 136 +++++++++++++
 tb/tb_uart_rx_deframer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, parity-type codes and legal oversampling ratios.
package uart_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_X8  = 8;
  localparam int PRESCALE_X16 = 16;
  localparam int PRESCALE_X32 = 32;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_CHECK  = 3'd5
  } rx_state_e;

  function automatic logic prescale_legal(input int p);
    return (p == PRESCALE_X8) || (p == PRESCALE_X16) || (p == PRESCALE_X32);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with a 3-point majority vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic restart_i,
  input  logic rx_i,
  output logic bit_o,
  output logic bit_done_o
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LastEdge = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] Samp0    = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] Samp1    = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] Samp2    = CW'(PRESCALE / 2 + 1);
  localparam logic [CW-1:0] VoteEdge = CW'(PRESCALE / 2 + 2);

  logic [CW-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]    samp_q;
  logic          bit_q;

  // A restart means the falling start edge was already seen one cycle ago.
  always_comb begin
    edge_cnt_d = '0;
    if (restart_i) begin
      edge_cnt_d = CW'(1);
    end else if (active_i && (edge_cnt_q != LastEdge)) begin
      edge_cnt_d = edge_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      edge_cnt_q <= '0;
      samp_q     <= '0;
      bit_q      <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      if (active_i) begin
        if (edge_cnt_q == Samp0) samp_q[0] <= rx_i;
        if (edge_cnt_q == Samp1) samp_q[1] <= rx_i;
        if (edge_cnt_q == Samp2) samp_q[2] <= rx_i;
        if (edge_cnt_q == VoteEdge) bit_q <= majority3(samp_q[0], samp_q[1], samp_q[2]);
      end
    end
  end

  assign bit_o      = bit_q;
  assign bit_done_o = active_i && (edge_cnt_q == LastEdge);

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start detect, LSB-first data, optional parity, stop check, strobed result.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BCW = $clog2(DATA_WIDTH);
  localparam logic [BCW-1:0] LastBit = BCW'(DATA_WIDTH - 1);

  rx_state_e             state_q;
  logic [BCW-1:0]        bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  par_en_q, par_typ_q;
  logic                  par_fail_q, stp_fail_q;
  logic                  data_valid_q, par_err_q, stp_err_q;

  logic active, restart, sampled_bit, bit_done, expected_par;

  assign active  = (state_q == RX_START) || (state_q == RX_DATA) ||
                   (state_q == RX_PARITY) || (state_q == RX_STOP);
  assign restart = (state_q == RX_CHECK) && !RX_IN;
  assign expected_par = (par_typ_q == PAR_ODD) ? ~^shift_q : ^shift_q;

  uart_rx_sampler #(
    .PRESCALE (PRESCALE)
  ) u_sampler (
    .clk_i      (clk),
    .rst_ni     (rst),
    .active_i   (active),
    .restart_i  (restart),
    .rx_i       (RX_IN),
    .bit_o      (sampled_bit),
    .bit_done_o (bit_done)
  );

  // Frame configuration is latched at the start edge so mid-frame changes cannot corrupt it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_data_q     <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_fail_q   <= 1'b0;
      stp_fail_q   <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (!RX_IN) begin
            state_q    <= RX_START;
            bit_cnt_q  <= '0;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            par_fail_q <= 1'b0;
            stp_fail_q <= 1'b0;
          end
        end
        RX_START: begin
          if (bit_done) begin
            state_q   <= sampled_bit ? RX_IDLE : RX_DATA;
            bit_cnt_q <= '0;
          end
        end
        RX_DATA: begin
          if (bit_done) begin
            shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
            if (bit_cnt_q == LastBit) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (bit_done) begin
            if (sampled_bit != expected_par) par_fail_q <= 1'b1;
            state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (bit_done) begin
            if (!sampled_bit) stp_fail_q <= 1'b1;
            state_q <= RX_CHECK;
          end
        end
        RX_CHECK: begin
          if (!par_fail_q && !stp_fail_q) begin
            p_data_q     <= shift_q;
            data_valid_q <= 1'b1;
          end else begin
            par_err_q <= par_fail_q;
            stp_err_q <= stp_fail_q;
          end
          par_fail_q <= 1'b0;
          stp_fail_q <= 1'b0;
          bit_cnt_q  <= '0;
          if (!RX_IN) begin
            state_q   <= RX_START;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
          end else begin
            state_q <= RX_IDLE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at PRESCALE=8 with hand-computed frames and expected bytes.
module tb_uart_rx_deframer;
  import uart_pkg::*;

  logic       clk;
  logic       rst;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       par_err;
  logic       stp_err;

  int checkCount = 0;
  int errorCount = 0;
  int cyc = 0;
  int lastStart = 0;

  int dvCount = 0;
  int parCount = 0;
  int stpCount = 0;
  int bothCount = 0;
  logic [7:0] dvHist [64];
  int dvCycleHist [64];

  int dvBase, parBase, stpBase;

  uart_rx_deframer #(
    .DATA_WIDTH (8),
    .PRESCALE   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output pulses are recorded on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (Data_Valid) begin
      if (dvCount < 64) begin
        dvHist[dvCount]      = P_DATA;
        dvCycleHist[dvCount] = cyc;
      end
      dvCount++;
    end
    if (par_err) parCount++;
    if (stp_err) stpCount++;
    if (Data_Valid && (par_err || stp_err)) bothCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic markBase();
    dvBase  = dvCount;
    parBase = parCount;
    stpBase = stpCount;
  endtask

  // One frame, 8 clocks per bit; PAR_EN/PAR_TYP are inverted after the start bit.
  task automatic applyStimulus(input logic [7:0] data, input logic parEn, input logic parTyp,
                               input logic parBit, input logic stopBit, input int glitchBit,
                               input int idleAfter);
    @(negedge clk);
    RX_IN     = 1'b0;
    PAR_EN    = parEn;
    PAR_TYP   = parTyp;
    lastStart = cyc;
    repeat (7) @(negedge clk);
    PAR_EN  = ~parEn;
    PAR_TYP = ~parTyp;
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        RX_IN = ((b == glitchBit) && (j == 5)) ? ~data[b] : data[b];
      end
    end
    if (parEn) begin
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        RX_IN = parBit;
      end
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      RX_IN = stopBit;
    end
    for (int j = 0; j < idleAfter; j++) begin
      @(negedge clk);
      RX_IN = 1'b1;
    end
  endtask

  initial begin
    rst     = 1'b0;
    RX_IN   = 1'b1;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;

    // Reset held with a toggling line
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      RX_IN = i[0];
    end
    checkOutput("rst_dv_count", dvCount, 0);
    checkOutput("rst_par_count", parCount, 0);
    checkOutput("rst_stp_count", stpCount, 0);
    checkOutput("rst_p_data", {24'h0, P_DATA}, 32'h0);
    @(negedge clk);
    RX_IN = 1'b1;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_state_idle", 32'(dut.state_q), 32'(RX_IDLE));

    // 0xB9 even parity: five ones, parity bit 1 is correct
    markBase();
    applyStimulus(8'hB9, 1'b1, PAR_EVEN, 1'b1, 1'b1, -1, 4);
    checkOutput("b9_even_dv", dvCount - dvBase, 1);
    checkOutput("b9_even_byte", {24'h0, dvHist[dvBase]}, 32'hB9);
    checkOutput("b9_even_p_data", {24'h0, P_DATA}, 32'hB9);
    checkOutput("b9_even_par", parCount - parBase, 0);
    checkOutput("b9_even_stp", stpCount - stpBase, 0);
    checkOutput("b9_even_latency", dvCycleHist[dvBase] - (lastStart + 1), 89);

    // 0xB9 odd parity with parity bit 1 is wrong
    markBase();
    applyStimulus(8'hB9, 1'b1, PAR_ODD, 1'b1, 1'b1, -1, 4);
    checkOutput("b9_odd_dv", dvCount - dvBase, 0);
    checkOutput("b9_odd_par", parCount - parBase, 1);
    checkOutput("b9_odd_stp", stpCount - stpBase, 0);
    checkOutput("b9_odd_p_data_hold", {24'h0, P_DATA}, 32'hB9);

    // 0x3C with a stop bit of 0
    markBase();
    applyStimulus(8'h3C, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, 4);
    checkOutput("stop0_dv", dvCount - dvBase, 0);
    checkOutput("stop0_stp", stpCount - stpBase, 1);
    checkOutput("stop0_par", parCount - parBase, 0);
    checkOutput("stop0_p_data_hold", {24'h0, P_DATA}, 32'hB9);

    markBase();
    applyStimulus(8'hA5, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 4);
    checkOutput("a5_dv", dvCount - dvBase, 1);
    checkOutput("a5_p_data", {24'h0, P_DATA}, 32'hA5);

    // Start glitch of 2 clocks
    markBase();
    @(negedge clk);
    RX_IN = 1'b0;
    repeat (2) @(negedge clk);
    RX_IN = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("glitch_dv", dvCount - dvBase, 0);
    checkOutput("glitch_flags", (parCount - parBase) + (stpCount - stpBase), 0);
    checkOutput("glitch_state_idle", 32'(dut.state_q), 32'(RX_IDLE));

    // 0x96 with a corrupted middle sample in data bit 2
    markBase();
    applyStimulus(8'h96, 1'b0, PAR_EVEN, 1'b0, 1'b1, 2, 4);
    checkOutput("vote_dv", dvCount - dvBase, 1);
    checkOutput("vote_byte", {24'h0, dvHist[dvBase]}, 32'h96);
    checkOutput("vote_latency", dvCycleHist[dvBase] - (lastStart + 1), 81);

    // Back-to-back 0x55 (no parity) then 0xAA (even parity, bit 0) with zero idle
    markBase();
    applyStimulus(8'h55, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 0);
    applyStimulus(8'hAA, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, 4);
    checkOutput("b2b_dv", dvCount - dvBase, 2);
    checkOutput("b2b_byte0", {24'h0, dvHist[dvBase]}, 32'h55);
    checkOutput("b2b_byte1", {24'h0, dvHist[dvBase + 1]}, 32'hAA);
    checkOutput("b2b_flags", (parCount - parBase) + (stpCount - stpBase), 0);

    // Reset during data bit 3 of a 0x3C frame
    markBase();
    @(negedge clk);
    RX_IN  = 1'b0;
    PAR_EN = 1'b0;
    repeat (7) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        RX_IN = (b == 2);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    RX_IN = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("abort_dv", dvCount - dvBase, 0);
    checkOutput("abort_flags", (parCount - parBase) + (stpCount - stpBase), 0);
    checkOutput("abort_p_data", {24'h0, P_DATA}, 32'h0);
    checkOutput("abort_state_idle", 32'(dut.state_q), 32'(RX_IDLE));

    // 0x0F odd parity: four ones, parity bit 1 is correct
    markBase();
    applyStimulus(8'h0F, 1'b1, PAR_ODD, 1'b1, 1'b1, -1, 4);
    checkOutput("recover_dv", dvCount - dvBase, 1);
    checkOutput("recover_p_data", {24'h0, P_DATA}, 32'h0F);
    checkOutput("recover_par", parCount - parBase, 0);

    checkOutput("dv_flag_exclusive", bothCount, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
